// File: rtl/uart_lite_pkg.sv
// uart_lite_pkg: shared constants and state types for the uart_lite_wb UART.
//   - Wishbone register addresses
//   - LSR bit positions
//   - TX / RX FSM state enums
package uart_lite_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_LSR  = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_FE   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_lite_rx.sv
// uart_lite_rx: 8N1 receiver. Synchronizes the serial line, finds the start
// edge and samples each bit at oversample count 7.
//
// Ports:
//   clk, rst      system clock, async active-high reset
//   tick_i        16x-oversample tick from the shared divider
//   srx_i         raw serial line (asynchronous)
//   rx_valid_o    1-cycle pulse: rx_data_o holds a good byte
//   rx_data_o     received byte
//   rx_fe_o       1-cycle pulse: stop bit sampled low, byte discarded
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | inside start bit; mid-sample of 1 means false start
// RX_DATA  | shifting in 8 data bits, LSB first
// RX_STOP  | waiting for stop-bit mid-sample, then report result
module uart_lite_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       srx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_fe_o
);
  import uart_lite_pkg::*;

  logic      sync1_q, sync2_q, prev_q;
  rx_state_e state_q, state_d;
  logic [3:0] ovs_q, ovs_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       mid, last;

  assign mid       = tick_i && (ovs_q == 4'd7);
  assign last      = tick_i && (ovs_q == 4'd15);
  assign rx_data_o = shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      ovs_q   <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      sync1_q <= srx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      ovs_q   <= ovs_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ovs_d      = ovs_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_valid_o = 1'b0;
    rx_fe_o    = 1'b0;
    if (state_q != RX_IDLE && tick_i) ovs_d = ovs_q + 4'd1;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          ovs_d   = 4'd0;
        end
      end
      RX_START: begin
        if (mid && sync2_q) begin
          state_d = RX_IDLE;
        end else if (last) begin
          state_d = RX_DATA;
          bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (mid) shift_d = {sync2_q, shift_q[7:1]};
        if (last) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Return to idle at mid-stop so a back-to-back start edge is caught.
        if (mid) begin
          state_d = RX_IDLE;
          if (sync2_q) rx_valid_o = 1'b1;
          else         rx_fe_o    = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_lite_wb.sv
// uart_lite_wb: minimal 16550-subset UART on an 8-bit, 3-bit-address
// Wishbone responder. 8N1 only, fixed baud (CLK_DIV clk per 16x tick).
//
// Ports:
//   clk, rst          system clock, async active-high reset
//   wb_adr_i/dat_i    register address / write data
//   wb_dat_o          registered read data, valid with wb_ack_o, else 0
//   wb_stb_i/we_i     strobe (held until ack) / write enable
//   wb_ack_o          1-cycle acknowledge, at most one per 2 cycles
//   srx_pad_i         serial input (asynchronous)
//   stx_pad_o         serial output
//   int_o             high while LSR.DR is set
//
// Registers: 0 read RBR / write THR, 5 read LSR, others read 0.
// Build option: define UART_LITE_RX_FIFO_EN to turn RBR into a 4-entry FIFO.
//
// state    | meaning
// TX_IDLE  | shifter empty; loads THR on the next tick when THR is full
// TX_START | driving start bit (0)
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving stop bit; reloads from THR at its end for no gap
module uart_lite_wb #(
  parameter logic [15:0] CLK_DIV = 16'd27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  input  logic       srx_pad_i,
  output logic       stx_pad_o,
  output logic       int_o
);
  import uart_lite_pkg::*;

  logic       ack_q, ack_d;
  logic [7:0] dat_q, dat_d;
  logic [15:0] div_q, div_d;
  logic       tick;

  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_ovs_q, tx_ovs_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_full_q, thr_full_d;
  logic       stx_q, stx_d;
  logic       tx_load;

  logic       oe_q, oe_d, fe_q, fe_d;
  logic       rx_valid, rx_fe, rx_overrun;
  logic [7:0] rx_data;
  logic       dr;
  logic [7:0] rbr_rd_data;
  logic [7:0] lsr;

  logic       acc, wr_thr, rd_rbr, rd_lsr, thre, temt;

  // An access is taken on the edge that raises ack; the ack itself blocks
  // the following cycle so a held strobe is not double-counted.
  assign acc    = wb_stb_i && !ack_q;
  assign wr_thr = acc &&  wb_we_i && (wb_adr_i == ADDR_DATA);
  assign rd_rbr = acc && !wb_we_i && (wb_adr_i == ADDR_DATA);
  assign rd_lsr = acc && !wb_we_i && (wb_adr_i == ADDR_LSR);
  assign thre   = !thr_full_q;
  assign temt   = thre && (tx_state_q == TX_IDLE);
  assign tick   = (div_q == 16'd0);

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign stx_pad_o = stx_q;
  assign int_o     = dr;

  uart_lite_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (tick),
    .srx_i      (srx_pad_i),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .rx_fe_o    (rx_fe)
  );

`ifdef UART_LITE_RX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [7:0] fifo_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       full, empty, push, pop;

  assign full        = (cnt_q == 3'd4);
  assign empty       = (cnt_q == 3'd0);
  assign pop         = rd_rbr && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push        = rx_valid && (!full || pop);
  assign rx_overrun  = rx_valid && full && !pop;
  assign dr          = !empty;
  assign rbr_rd_data = empty ? 8'h00 : fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = rx_data;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    cnt_d = cnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= 8'h00;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  logic [7:0] rbr_q, rbr_d;
  logic       dr_q, dr_d;

  // A byte arriving on the same cycle its predecessor is read is kept.
  assign rx_overrun  = rx_valid && dr_q && !rd_rbr;
  assign dr          = dr_q;
  assign rbr_rd_data = rbr_q;

  always_comb begin
    rbr_d = rbr_q;
    dr_d  = dr_q;
    if (rd_rbr) dr_d = 1'b0;
    if (rx_valid && !rx_overrun) begin
      rbr_d = rx_data;
      dr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbr_q <= 8'h00;
      dr_q  <= 1'b0;
    end else begin
      rbr_q <= rbr_d;
      dr_q  <= dr_d;
    end
  end
`endif

  always_comb begin
    lsr           = 8'h00;
    lsr[LSR_DR]   = dr;
    lsr[LSR_OE]   = oe_q;
    lsr[LSR_FE]   = fe_q;
    lsr[LSR_THRE] = thre;
    lsr[LSR_TEMT] = temt;
  end

  always_comb begin
    ack_d = acc;
    dat_d = 8'h00;
    if (acc && !wb_we_i) begin
      case (wb_adr_i)
        ADDR_DATA: dat_d = rbr_rd_data;
        ADDR_LSR:  dat_d = lsr;
        default:   dat_d = 8'h00;
      endcase
    end
    oe_d = oe_q;
    fe_d = fe_q;
    if (rd_lsr) begin
      oe_d = 1'b0;
      fe_d = 1'b0;
    end
    if (rx_overrun) oe_d = 1'b1;
    if (rx_fe)      fe_d = 1'b1;
    div_d = tick ? (CLK_DIV - 16'd1) : (div_q - 16'd1);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_ovs_d   = tx_ovs_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    tx_load    = 1'b0;
    if (wr_thr && !thr_full_q) begin
      thr_d      = wb_dat_i;
      thr_full_d = 1'b1;
    end
    if (tx_state_q != TX_IDLE && tick) tx_ovs_d = tx_ovs_q + 4'd1;
    case (tx_state_q)
      TX_IDLE: begin
        if (tick && thr_full_q) tx_load = 1'b1;
      end
      TX_START: begin
        if (tick && tx_ovs_q == 4'd15) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tick && tx_ovs_q == 4'd15) begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tick && tx_ovs_q == 4'd15) begin
          if (thr_full_q) tx_load = 1'b1;
          else            tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Loading only happens with THR full, and a write only lands with THR
    // empty, so the two never collide on thr_full_d.
    if (tx_load) begin
      tx_state_d = TX_START;
      tx_shift_d = thr_q;
      tx_ovs_d   = 4'd0;
      thr_full_d = 1'b0;
    end
    case (tx_state_d)
      TX_START: stx_d = 1'b0;
      TX_DATA:  stx_d = tx_shift_d[0];
      default:  stx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q      <= 1'b0;
      dat_q      <= 8'h00;
      div_q      <= 16'd0;
      oe_q       <= 1'b0;
      fe_q       <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_ovs_q   <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      thr_q      <= 8'h00;
      thr_full_q <= 1'b0;
      stx_q      <= 1'b1;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      div_q      <= div_d;
      oe_q       <= oe_d;
      fe_q       <= fe_d;
      tx_state_q <= tx_state_d;
      tx_ovs_q   <= tx_ovs_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      stx_q      <= stx_d;
    end
  end

endmodule
